// File: rtl/dot_product_accumulator.sv
// Signed 64-bit dot-product accumulator fed by an upstream multiplier.
// Define DOT_ACC_SAT_EN to saturate on overflow instead of wrapping.
module dot_product_accumulator #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [63:0]      prod_in,
  input  logic             prod_valid,
  output logic [63:0]      acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [63:0] SMAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SMIN = 64'h8000_0000_0000_0000;

  state_e           state_q, state_d;
  logic [63:0]      acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [63:0] sum;
  logic [63:0] add_res;
  logic        add_ovf;
  logic        accept;
  logic        last;

  assign sum     = acc_q + prod_in;
  assign add_ovf = (acc_q[63] == prod_in[63]) &&
                   (sum[63] != acc_q[63]);

`ifdef DOT_ACC_SAT_EN
  // Clamp toward the sign of the operands on overflow
  assign add_res = add_ovf ? (acc_q[63] ? SMIN : SMAX) : sum;
`else
  assign add_res = sum;
`endif

  // cnt guard keeps the counter from ever wrapping below zero
  assign accept = (state_q == ACCUM) && prod_valid &&
                  (cnt_q != '0);
  assign last   = accept && (cnt_q == LEN_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start)
          state_d = (len == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: clear on start, add on accepted product
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if ((state_q == IDLE) && start) begin
      acc_d = '0;
      ovf_d = 1'b0;
      cnt_d = len;
    end else if (accept) begin
      acc_d = add_res;
      cnt_d = cnt_q - LEN_W'(1);
      ovf_d = ovf_q | add_ovf;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    acc_out   = acc_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Randomized self-checking bench for dot_product_accumulator.
// Reference model uses exact wide arithmetic with range checks.
module tb_dot_product_accumulator;

  localparam int LEN_W = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [63:0]      prod_in;
  logic             prod_valid;
  logic [63:0]      acc_out;
  logic             out_valid;
  logic             out_ready;
  logic             ovf;
  logic             busy;

  int errors = 0;
  int checks = 0;

  logic signed [63:0] prods[$];

  localparam logic signed [65:0] MAXV = 66'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [65:0] MINV = -MAXV - 66'sd1;

  dot_product_accumulator #(.LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .acc_out    (acc_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ovf        (ovf),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Exact-sum model: any result outside the signed 64-bit range
  // is an overflow; the stored value then wraps or clamps.
  task automatic model(output logic [63:0] a, output logic o);
    logic signed [63:0] acc;
    logic signed [65:0] s;
    acc = '0;
    o = 1'b0;
    foreach (prods[i]) begin
      s = acc + prods[i];
      if (s > MAXV || s < MINV) begin
        o = 1'b1;
`ifdef DOT_ACC_SAT_EN
        acc = (s > MAXV) ? MAXV[63:0] : MINV[63:0];
`else
        acc = s[63:0];
`endif
      end else begin
        acc = s[63:0];
      end
    end
    a = acc;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One full transaction using the products held in prods
  task automatic run_txn(input int maxgap, input int rwait);
    logic [63:0] ea, held;
    logic        eo;
    int          n;
    n = prods.size();
    model(ea, eo);
    start = 1'b1;
    len   = LEN_W'(n);
    tick();
    start = 1'b0;
    len   = LEN_W'($urandom);
    for (int i = 0; i < n; i++) begin
      int g;
      chk("busy_accum", busy, 1);
      g = $urandom_range(0, maxgap);
      repeat (g) begin
        prod_valid = 1'b0;
        prod_in    = rnd64();
        tick();
        chk("ov_gap", out_valid, 0);
      end
      prod_valid = 1'b1;
      prod_in    = prods[i];
      tick();
      prod_valid = 1'b0;
      if (i < n - 1) chk("ov_early", out_valid, 0);
    end
    chk("ov_done", out_valid, 1);
    chk("acc", acc_out, ea);
    chk("ovf", ovf, eo);
    held = acc_out;
    repeat (rwait) begin
      prod_valid = $urandom_range(0, 1) == 1;
      prod_in    = rnd64();
      start      = $urandom_range(0, 1) == 1;
      tick();
      chk("hold_ov", out_valid, 1);
      chk("hold_acc", acc_out, held);
      chk("hold_ovf", ovf, eo);
    end
    prod_valid = 1'b0;
    start      = 1'b0;
    out_ready  = 1'b1;
    tick();
    out_ready  = 1'b0;
    chk("ov_idle", out_valid, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    len        = '0;
    prod_in    = '0;
    prod_valid = 1'b0;
    out_ready  = 1'b0;
    repeat (2) tick();
    chk("rst_acc", acc_out, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;

    // Products offered in IDLE must be ignored, then len=0
    prod_valid = 1'b1;
    prod_in    = 64'd123;
    repeat (2) tick();
    prod_valid = 1'b0;
    chk("idle_pv_acc", acc_out, 0);
    chk("idle_pv_busy", busy, 0);
    prods = {};
    run_txn(0, 1);

    // 5, -2, 7 back to back
    prods = {64'sd5, -64'sd2, 64'sd7};
    run_txn(0, 0);
    chk("dir_acc10", acc_out, 64'd10);
    chk("dir_ovf0", ovf, 0);

    // Gapped products, consumer stalls 5 cycles
    prods = {64'sd100, -64'sd40, 64'sd3, 64'sd1};
    run_txn(3, 5);

    // Positive overflow
    prods = {64'sh7FFF_FFFF_FFFF_FFFF, 64'sd1};
    run_txn(1, 0);
    chk("ovf_set", ovf, 1);
`ifdef DOT_ACC_SAT_EN
    chk("ovf_acc", acc_out, 64'h7FFF_FFFF_FFFF_FFFF);
`else
    chk("ovf_acc", acc_out, 64'h8000_0000_0000_0000);
`endif

    // Reset after 2 of 5 products
    start = 1'b1;
    len   = LEN_W'(5);
    tick();
    start = 1'b0;
    prod_valid = 1'b1;
    prod_in    = 64'd11;
    repeat (2) tick();
    prod_valid = 1'b0;
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_acc", acc_out, 0);
    chk("mr_busy", busy, 0);
    chk("mr_ov", out_valid, 0);
    chk("mr_ovf", ovf, 0);
    #1;
    rst_n = 1'b1;
    prods = {-64'sd9};
    run_txn(0, 0);
    chk("mr_acc_m9", acc_out, 64'hFFFF_FFFF_FFFF_FFF7);

    // Start in DONE together with out_ready is ignored
    start = 1'b1;
    len   = LEN_W'(1);
    tick();
    start = 1'b0;
    prod_valid = 1'b1;
    prod_in    = 64'd3;
    tick();
    prod_valid = 1'b0;
    chk("d34_ov", out_valid, 1);
    chk("d34_acc", acc_out, 64'd3);
    start     = 1'b1;
    len       = LEN_W'(4);
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    chk("d34_idle", busy, 0);
    chk("d34_ov0", out_valid, 0);
    prods = {64'sd8, -64'sd20};
    run_txn(0, 0);

    // Random transactions
    for (int t = 0; t < 40; t++) begin
      int n;
      n = $urandom_range(0, 6);
      prods = {};
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 1) == 1)
          prods.push_back(rnd64());
        else
          prods.push_back(64'(signed'($urandom_range(0, 2000)) - 1000));
      end
      run_txn($urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
